// File: rtl/ex_mem_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module  : ex_mem_pipe_stage
// Brief   : EX->MEM pipeline register, 2-entry skid buffer, registered ready.
// Revision: 1.0  initial release
// ============================================================================
module ex_mem_pipe_stage #(
    parameter int                DATA_W   = 32,
    parameter int                PC_W     = 32,
    parameter int                INS_W    = 32,
    parameter logic [PC_W-1:0]   RESET_PC = 32'h00003000,
    parameter logic [INS_W-1:0]  NOP_INS  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] write_data,
    input  logic [PC_W-1:0]   pc8,
    input  logic [INS_W-1:0]  ins,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_out_m,
    output logic [DATA_W-1:0] write_data_m,
    output logic [PC_W-1:0]   pc8_m,
    output logic [INS_W-1:0]  ins_m,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] c_DATA_ZERO = '0;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [1:0]        r_occupancy;
    logic [DATA_W-1:0] r_main_alu;
    logic [DATA_W-1:0] r_main_wd;
    logic [PC_W-1:0]   r_main_pc8;
    logic [INS_W-1:0]  r_main_ins;
    logic [DATA_W-1:0] r_skid_alu;
    logic [DATA_W-1:0] r_skid_wd;
    logic [PC_W-1:0]   r_skid_pc8;
    logic [INS_W-1:0]  r_skid_ins;

    logic w_push;
    logic w_pop;

    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    // Every output comes straight from a register, so MEM never sees logic
    // depending on EX inputs and EX never sees logic depending on out_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occupancy <= 2'd0;
            r_main_alu  <= c_DATA_ZERO;
            r_main_wd   <= c_DATA_ZERO;
            r_main_pc8  <= RESET_PC;
            r_main_ins  <= NOP_INS;
            r_skid_alu  <= c_DATA_ZERO;
            r_skid_wd   <= c_DATA_ZERO;
            r_skid_pc8  <= RESET_PC;
            r_skid_ins  <= NOP_INS;
        end else if (flush) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occupancy <= 2'd0;
            r_main_alu  <= c_DATA_ZERO;
            r_main_wd   <= c_DATA_ZERO;
            r_main_pc8  <= RESET_PC;
            r_main_ins  <= NOP_INS;
            r_skid_alu  <= c_DATA_ZERO;
            r_skid_wd   <= c_DATA_ZERO;
            r_skid_pc8  <= RESET_PC;
            r_skid_ins  <= NOP_INS;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_state     <= S_ONE;
                        r_out_valid <= 1'b1;
                        r_occupancy <= 2'd1;
                        r_main_alu  <= alu_out;
                        r_main_wd   <= write_data;
                        r_main_pc8  <= pc8;
                        r_main_ins  <= ins;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        r_main_alu <= alu_out;
                        r_main_wd  <= write_data;
                        r_main_pc8 <= pc8;
                        r_main_ins <= ins;
                    end else if (w_push) begin
                        r_state     <= S_TWO;
                        r_in_ready  <= 1'b0;
                        r_occupancy <= 2'd2;
                        r_skid_alu  <= alu_out;
                        r_skid_wd   <= write_data;
                        r_skid_pc8  <= pc8;
                        r_skid_ins  <= ins;
                    end else if (w_pop) begin
                        r_state     <= S_EMPTY;
                        r_out_valid <= 1'b0;
                        r_occupancy <= 2'd0;
                        r_main_alu  <= c_DATA_ZERO;
                        r_main_wd   <= c_DATA_ZERO;
                        r_main_pc8  <= RESET_PC;
                        r_main_ins  <= NOP_INS;
                    end
                end
                S_TWO: begin
                    // Skid entry is older-second: it only ever moves into main.
                    if (w_pop) begin
                        r_state     <= S_ONE;
                        r_in_ready  <= 1'b1;
                        r_occupancy <= 2'd1;
                        r_main_alu  <= r_skid_alu;
                        r_main_wd   <= r_skid_wd;
                        r_main_pc8  <= r_skid_pc8;
                        r_main_ins  <= r_skid_ins;
                        r_skid_alu  <= c_DATA_ZERO;
                        r_skid_wd   <= c_DATA_ZERO;
                        r_skid_pc8  <= RESET_PC;
                        r_skid_ins  <= NOP_INS;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_occupancy <= 2'd0;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign occupancy    = r_occupancy;
    assign alu_out_m    = r_main_alu;
    assign write_data_m = r_main_wd;
    assign pc8_m        = r_main_pc8;
    assign ins_m        = r_main_ins;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_mem_pipe_stage
// Brief   : Scoreboard bench for the EX->MEM skid-buffered pipeline stage.
// Revision: 1.0  initial release
// ============================================================================
module tb_ex_mem_pipe_stage;

    localparam logic [31:0] c_RESET_PC = 32'h00003000;
    localparam logic [31:0] c_NOP_INS  = 32'h0;
    localparam logic [127:0] c_BUBBLE  = {32'h0, 32'h0, c_RESET_PC, c_NOP_INS};

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic [31:0] pc8;
    logic [31:0] ins;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out_m;
    logic [31:0] write_data_m;
    logic [31:0] pc8_m;
    logic [31:0] ins_m;
    logic [1:0]  occupancy;

    int total;
    int bad;
    logic [127:0] r_q[$];

    ex_mem_pipe_stage #(
        .DATA_W   (32),
        .PC_W     (32),
        .INS_W    (32),
        .RESET_PC (c_RESET_PC),
        .NOP_INS  (c_NOP_INS)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_out      (alu_out),
        .write_data   (write_data),
        .pc8          (pc8),
        .ins          (ins),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_out_m    (alu_out_m),
        .write_data_m (write_data_m),
        .pc8_m        (pc8_m),
        .ins_m        (ins_m),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Compare every visible output against the reference queue.
    task automatic check_outputs(input string tag);
        logic [127:0] exp_p;
        exp_p = (r_q.size() > 0) ? r_q[0] : c_BUBBLE;
        chk({tag, ".occ"},       {126'd0, occupancy}, 128'(r_q.size()));
        chk({tag, ".in_ready"},  {127'd0, in_ready},  {127'd0, (r_q.size() < 2)});
        chk({tag, ".out_valid"}, {127'd0, out_valid}, {127'd0, (r_q.size() > 0)});
        chk({tag, ".payload"},   {alu_out_m, write_data_m, pc8_m, ins_m}, exp_p);
    endtask

    // Called at posedge+1: drive inputs, check, update model, advance one edge.
    task automatic cycle(input string tag, input logic v, input logic rdy, input logic fl,
                         input logic [127:0] p);
        logic push;
        logic pop;
        in_valid   = v;
        out_ready  = rdy;
        flush      = fl;
        {alu_out, write_data, pc8, ins} = p;
        check_outputs(tag);
        push = v && (r_q.size() < 2);
        pop  = rdy && (r_q.size() > 0);
        if (fl) begin
            r_q.delete();
        end else begin
            if (pop)  void'(r_q.pop_front());
            if (push) r_q.push_back(p);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd_payload();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_out   = '0;
        write_data = '0;
        pc8       = '0;
        ins       = '0;

        // Reset state, then release with no traffic.
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle("idle0", 1'b0, 1'b0, 1'b0, '0);
        cycle("idle1", 1'b0, 1'b1, 1'b0, '0);

        // Streaming: back-to-back pushes with MEM always ready.
        for (int i = 1; i <= 4; i++)
            cycle("stream", 1'b1, 1'b1, 1'b0, {32'(i), 32'(i + 100), 32'(i * 8), 32'(i + 32'h40)});
        cycle("stream_tail", 1'b0, 1'b1, 1'b0, '0);
        cycle("stream_done", 1'b0, 1'b1, 1'b0, '0);

        // Back-pressure: A then B fill both entries, third push held off.
        cycle("bp_a",  1'b1, 1'b0, 1'b0, {32'h11, 32'h12, 32'h13, 32'hA});
        cycle("bp_b",  1'b1, 1'b0, 1'b0, {32'h21, 32'h22, 32'h23, 32'hB});
        cycle("bp_c",  1'b1, 1'b0, 1'b0, {32'h31, 32'h32, 32'h33, 32'hC});
        cycle("bp_c2", 1'b1, 1'b0, 1'b0, {32'h31, 32'h32, 32'h33, 32'hC});
        cycle("bp_popa", 1'b0, 1'b1, 1'b0, '0);
        cycle("bp_popb", 1'b0, 1'b1, 1'b0, '0);
        cycle("bp_done", 1'b0, 1'b1, 1'b0, '0);

        // Flush with two held entries and a same-cycle push attempt.
        cycle("fl_a", 1'b1, 1'b0, 1'b0, {32'h51, 32'h52, 32'h53, 32'h54});
        cycle("fl_b", 1'b1, 1'b0, 1'b0, {32'h61, 32'h62, 32'h63, 32'h64});
        cycle("fl_go", 1'b1, 1'b1, 1'b1, {32'h71, 32'h72, 32'h73, 32'hC});
        cycle("fl_after", 1'b0, 1'b1, 1'b0, '0);
        // Flush with one entry: the accepted push must be discarded.
        cycle("fl1_a", 1'b1, 1'b0, 1'b0, {32'h81, 32'h82, 32'h83, 32'h84});
        cycle("fl1_go", 1'b1, 1'b0, 1'b1, {32'h91, 32'h92, 32'h93, 32'h94});
        cycle("fl1_after", 1'b0, 1'b1, 1'b0, '0);

        // Async reset between edges while stalled at occupancy 2.
        cycle("ar_a", 1'b1, 1'b0, 1'b0, {32'hA1, 32'hA2, 32'hA3, 32'hA4});
        cycle("ar_b", 1'b1, 1'b0, 1'b0, {32'hB1, 32'hB2, 32'hB3, 32'hB4});
        check_outputs("ar_full");
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b0;
        #2;
        r_q.delete();
        check_outputs("ar_async");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle("ar_after", 1'b0, 1'b1, 1'b0, '0);

        // Random traffic against the reference queue.
        for (int n = 0; n < 10000; n++)
            cycle("rand", ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 63) == 0), rnd_payload());
        // Drain.
        for (int n = 0; n < 4; n++)
            cycle("drain", 1'b0, 1'b1, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
